// File: rtl/logits_argmax.sv
// logits_argmax: per-row signed argmax over a latched logits matrix, one element per clock
module logits_argmax #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_SIZE-1:0]           in_matrix [MATRIX_SIZE][MATRIX_SIZE],
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MATRIX_SIZE)-1:0] class_idx [MATRIX_SIZE],
  output logic [DATA_SIZE-1:0]           max_val   [MATRIX_SIZE]
);
  localparam int IW = $clog2(MATRIX_SIZE);
  localparam logic [IW-1:0] LAST = IW'(MATRIX_SIZE - 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_SIZE-1:0] mat [MATRIX_SIZE][MATRIX_SIZE];
  logic [IW-1:0] r, c, run_idx, new_idx;
  logic [DATA_SIZE-1:0] run_max, elem, new_max;
  logic take, row_end, last;
  // Running-max update: column 0 always loads, later columns only on strictly greater
  always_comb begin
    elem    = mat[r][c];
    take    = (c == '0) || ($signed(elem) > $signed(run_max));
    new_max = take ? elem : run_max;
    new_idx = take ? c : run_idx;
    row_end = c == LAST;
    last    = row_end && r == LAST;
  end
  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = state != IDLE;
    done      = state == DONE;
    state_nxt = (state == IDLE && start) ? SCAN :
                (state == SCAN && last)  ? DONE :
                (state == DONE)          ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // Snapshot of the input so later changes cannot disturb a running job
  always_ff @(posedge clk)
    if (!reset && state == IDLE && start) mat <= in_matrix;
  // Scan counters, running max and per-row results
  always_ff @(posedge clk) begin
    if (reset) begin
      r       <= '0;
      c       <= '0;
      run_max <= '0;
      run_idx <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        class_idx[i] <= '0;
        max_val[i]   <= '0;
      end
    end else if (state == IDLE && start) begin
      r <= '0;
      c <= '0;
    end else if (state == SCAN) begin
      run_max <= new_max;
      run_idx <= new_idx;
      if (row_end) begin
        class_idx[r] <= new_idx;
        max_val[r]   <= new_max;
        c            <= '0;
        r            <= r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_logits_argmax.sv
// tb_logits_argmax: directed checks of logits_argmax timing, tie/sign handling and reset
module tb_logits_argmax;
  logic clk, reset, start, busy, done;
  logic [7:0] m [16][16];
  logic [3:0] class_idx [16];
  logic [7:0] max_val [16];
  int total = 0, passed = 0;
  int done_cnt, first_done, busy_ok, busy_end;

  logits_argmax #(.MATRIX_SIZE(16), .DATA_SIZE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_matrix(m),
    .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic build();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) m[r][c] = 8'h00;
    for (int c = 0; c < 16; c++) begin
      m[0][c]  = 8'(c % 3 + 1);
      m[1][c]  = 8'h80;
      m[2][c]  = 8'hFF;
      m[3][c]  = 8'd5;
      m[4][c]  = 8'(c);
      m[15][c] = 8'hFB;
    end
    m[1][9]  = 8'h7F;
    m[2][4]  = 8'h80;
    m[15][15] = 8'hFD;
  endtask

  task automatic zero();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) m[r][c] = 8'h00;
  endtask

  initial begin
    reset = 1;
    start = 0;
    build();
    tick();
    tick();
    reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_idx0", class_idx[0], 0);
    chk("reset_val15", max_val[15], 0);

    start = 1;
    tick();
    start = 0;
    chk("busy_after_e0", busy, 1);
    done_cnt = 0;
    first_done = 0;
    busy_ok = 1;
    busy_end = 1;
    for (int k = 1; k <= 262; k++) begin
      if (k == 10) zero();
      start = (k == 50 || k == 255);
      tick();
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      if (k <= 256 && !busy) busy_ok = 0;
      if (k == 257) busy_end = busy;
    end
    start = 0;
    chk("done_count", done_cnt, 1);
    chk("done_cycle", first_done, 256);
    chk("busy_continuous", busy_ok, 1);
    chk("busy_cleared_e257", busy_end, 0);
    chk("row0_idx", class_idx[0], 2);
    chk("row0_val", $signed(max_val[0]), 3);
    chk("row1_idx", class_idx[1], 9);
    chk("row1_val", $signed(max_val[1]), 127);
    chk("row2_idx", class_idx[2], 0);
    chk("row2_val", $signed(max_val[2]), -1);
    chk("row3_idx", class_idx[3], 0);
    chk("row3_val", $signed(max_val[3]), 5);
    chk("row4_idx", class_idx[4], 15);
    chk("row4_val", $signed(max_val[4]), 15);
    chk("row7_val", $signed(max_val[7]), 0);
    chk("row15_idx", class_idx[15], 15);
    chk("row15_val", $signed(max_val[15]), -3);

    build();
    reset = 1;
    start = 1;
    tick();
    reset = 0;
    start = 0;
    chk("reset_over_start_busy", busy, 0);
    tick();
    chk("reset_over_start_idle", busy, 0);

    start = 1;
    tick();
    start = 0;
    repeat (99) tick();
    chk("midscan_busy", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_idx1", class_idx[1], 0);
    chk("abort_val0", max_val[0], 0);
    done_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);

    for (int c = 0; c < 16; c++) m[0][c] = 8'h00;
    m[0][7] = 8'd9;
    start = 1;
    tick();
    start = 0;
    first_done = 0;
    for (int k = 1; k <= 300 && first_done == 0; k++) begin
      tick();
      if (done) first_done = k;
    end
    chk("fresh_done_cycle", first_done, 256);
    chk("fresh_row0_idx", class_idx[0], 7);
    chk("fresh_row0_val", $signed(max_val[0]), 9);
    chk("fresh_row1_idx", class_idx[1], 9);
    chk("fresh_row2_val", $signed(max_val[2]), -1);
    tick();
    chk("fresh_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
